risc_v_mem_bus_arbiter: RTL
===========================

# risc_v_mem_bus_arbiter

Two-requester arbiter in front of `risc_v_mem_ctrl` that shares the single memory bus (`mem_bus_*`) between the load/store unit (port 0) and a secondary master (port 1: instruction fetch / debug loader / DMA). Each port uses a valid/ready request handshake and receives a registered one-cycle response. The response carries read data and the address-decode error flags from the memory controller. Port 0 has priority; a starvation counter guarantees port 1 service.

## Interface
- `MAX_HOLD`, 4: max consecutive port-0 grants while port 1 is waiting; legal range 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `reqN_valid`  in  1  port N (N=0,1) request present.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  DATA_32_W  byte address.
- `reqN_wr_data`  in  DATA_32_W  write data.
- `reqN_ready`  out  1  grant; the transfer is accepted in a cycle when `reqN_valid & reqN_ready`.
- `rspN_valid`  out  1  response for the transfer port N had accepted in the previous cycle.
- `rspN_rd_data`  out  DATA_32_W  read data; 0 for writes.
- `rspN_error`  out  1  decode error for the accepted address.
- `mem_bus_rd_addr`, `mem_bus_wr_addr`  out  DATA_32_W  bus addresses.
- `mem_bus_read`, `mem_bus_write`  out  1  bus strobes.
- `mem_bus_wr_data`  out  DATA_32_W  bus write data.
- `mem_bus_rd_data`  in  DATA_32_W  bus read data, valid in the same cycle as the address.
- `mem_bus_rd_addr_error`, `mem_bus_wr_addr_error`  in  1  decode errors from `risc_v_mem_ctrl`.

## Operation
- Grant is combinational in each cycle, with at most one grant per cycle:
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid and `starve_cnt < MAX_HOLD`: grant 0.
  - Both valid and `starve_cnt == MAX_HOLD`: grant 1.
  - Neither valid: no grant, `reqN_ready` = 0.
- `starve_cnt`, 4 bits:
  - Increments on a port-0 grant while `req1_valid` = 1.
  - Clears on a port-1 grant, or in any cycle where `req1_valid` = 0.
  - Never exceeds `MAX_HOLD`.
- Bus drive for the granted port:
  - Read: `mem_bus_read` = 1 and `mem_bus_rd_addr` = addr.
  - Write: `mem_bus_write` = 1, `mem_bus_wr_addr` = addr and `mem_bus_wr_data` = data.
  - All unused bus outputs are 0. With no grant, all `mem_bus_*` outputs are 0.
- Response registers, loaded on the accepting edge:
  - `rspN_valid` is set for the granted port only.
  - `rspN_rd_data` takes `mem_bus_rd_data` on a read, 0 on a write.
  - `rspN_error` takes `mem_bus_rd_addr_error` on a read, `mem_bus_wr_addr_error` on a write.
- A port that was not granted has `rspN_valid` = 0 in the next cycle. Its `rspN_rd_data` and `rspN_error` return to 0.
- An errored transfer still consumes its grant and still produces a response. The arbiter does not suppress the strobe; gating invalid addresses is done by `risc_v_mem_ctrl`.
- Requesters hold `reqN_*` stable while valid and not ready. The arbiter does not buffer requests that were not accepted.

## Timing
- Request to bus: 0 cycles (same cycle as the grant).
- Request to response: 1 cycle. Back-to-back accepts give back-to-back responses, one per cycle, with no bubbles.
- Throughput: 1 transfer per cycle total, shared between the ports.
- Worst-case wait for port 1 while port 0 is continuously valid: `MAX_HOLD` cycles. Port 1 is granted in cycle `MAX_HOLD`+1 of its wait.
- Reset (`rst` = 0 sampled at an edge):
  - After the edge: `rspN_valid`, `rspN_rd_data`, `rspN_error` and `starve_cnt` are 0.
  - While `rst` = 0: `reqN_ready` = 0 and all `mem_bus_*` outputs are 0, regardless of requests.
  - A response pending at that edge is discarded.
- First grant is possible in the first cycle with `rst` = 1.

## Test plan
- **Reset:** hold `rst` = 0 with both ports valid for 3 cycles.
  - Required: all outputs 0 throughout.
  - Release `rst`: port 0 is granted in the same cycle.
- **Single-port read:** port 0 reads `0x10010000`, and the memory returns `0x000000ff`.
  - Required: `mem_bus_read` = 1 and `mem_bus_rd_addr` = `0x10010000` in cycle T.
  - Required: `rsp0_valid` = 1 and `rsp0_rd_data` = `0x000000ff` in T+1, `rsp0_error` = 0.
- **Starvation:** both ports continuously valid with `MAX_HOLD` = 4.
  - Required grant sequence: 0,0,0,0,1,0,0,0,0,1.
  - Required: `starve_cnt` peaks at 4 and never exceeds it.
- **Decode error:** port 1 writes `0x10f10000`.
  - Required: `mem_bus_write` = 1.
  - Required next cycle: `rsp1_valid` = 1, `rsp1_error` = 1, `rsp1_rd_data` = 0.
- **Counter clear:** port 1 drops valid after 2 port-0 grants, then reasserts.
  - Required: `starve_cnt` is 0 in the cycle port 1 is idle.
  - Required: port 0 again wins 4 grants before port 1 is granted.
- **Reset mid-transfer:** assert `rst` = 0 on the edge that accepts a port-0 write to `0x7fffeffc`.
  - Required: `rsp0_valid` stays 0.
  - Required: no further bus strobes until `rst` returns to 1.

Source files
------------

// File: rtl/risc_v_mem_bus_arbiter.sv
// Two-port arbiter for the shared memory bus: port 0 has priority, and a
// starvation counter forces a port-1 grant after MAX_HOLD consecutive port-0 wins.
module risc_v_mem_bus_arbiter #(
    parameter int DATA_32_W = 32,
    parameter int MAX_HOLD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [DATA_32_W-1:0] req0_addr,
    input  logic [DATA_32_W-1:0] req0_wr_data,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [DATA_32_W-1:0] rsp0_rd_data,
    output logic                 rsp0_error,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [DATA_32_W-1:0] req1_addr,
    input  logic [DATA_32_W-1:0] req1_wr_data,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [DATA_32_W-1:0] rsp1_rd_data,
    output logic                 rsp1_error,
    output logic [DATA_32_W-1:0] mem_bus_rd_addr,
    output logic [DATA_32_W-1:0] mem_bus_wr_addr,
    output logic                 mem_bus_read,
    output logic                 mem_bus_write,
    output logic [DATA_32_W-1:0] mem_bus_wr_data,
    input  logic [DATA_32_W-1:0] mem_bus_rd_data,
    input  logic                 mem_bus_rd_addr_error,
    input  logic                 mem_bus_wr_addr_error
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic                 gnt0_s, gnt1_s, any_gnt_s, sel_write_s, sel_err_s;
    logic [DATA_32_W-1:0] sel_addr_s, sel_data_s, sel_rd_data_s;
    logic [3:0]           starve_cnt_q, starve_cnt_d;
    logic                 rsp0_valid_q, rsp0_valid_d, rsp0_error_q, rsp0_error_d;
    logic                 rsp1_valid_q, rsp1_valid_d, rsp1_error_q, rsp1_error_d;
    logic [DATA_32_W-1:0] rsp0_rd_data_q, rsp0_rd_data_d, rsp1_rd_data_q, rsp1_rd_data_d;

    // Grant selection; nothing is granted while reset is held low.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst) begin
            gnt0_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (starve_cnt_q >= HOLD_MAX) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
        end
    end

    // Request mux for whichever port holds the grant.
    always_comb begin
        any_gnt_s = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            sel_write_s = req1_write;
            sel_addr_s  = req1_addr;
            sel_data_s  = req1_wr_data;
        end else begin
            sel_write_s = req0_write;
            sel_addr_s  = req0_addr;
            sel_data_s  = req0_wr_data;
        end
    end

    // Bus drive; every unused bus field is forced to zero.
    always_comb begin
        mem_bus_read    = 1'b0;
        mem_bus_write   = 1'b0;
        mem_bus_rd_addr = {DATA_32_W{1'b0}};
        mem_bus_wr_addr = {DATA_32_W{1'b0}};
        mem_bus_wr_data = {DATA_32_W{1'b0}};
        if (any_gnt_s && sel_write_s) begin
            mem_bus_write   = 1'b1;
            mem_bus_wr_addr = sel_addr_s;
            mem_bus_wr_data = sel_data_s;
        end else if (any_gnt_s) begin
            mem_bus_read    = 1'b1;
            mem_bus_rd_addr = sel_addr_s;
        end else begin
            mem_bus_read    = 1'b0;
        end
    end

    // Starvation counter: counts port-0 wins only while port 1 keeps waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req1_valid || gnt1_s) begin
            starve_cnt_d = 4'd0;
        end else if (gnt0_s && (starve_cnt_q < HOLD_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Next response: only the granted port sees data/error, the other returns to zero.
    always_comb begin
        sel_rd_data_s  = sel_write_s ? {DATA_32_W{1'b0}} : mem_bus_rd_data;
        sel_err_s      = sel_write_s ? mem_bus_wr_addr_error : mem_bus_rd_addr_error;
        rsp0_valid_d   = gnt0_s;
        rsp0_rd_data_d = gnt0_s ? sel_rd_data_s : {DATA_32_W{1'b0}};
        rsp0_error_d   = gnt0_s ? sel_err_s : 1'b0;
        rsp1_valid_d   = gnt1_s;
        rsp1_rd_data_d = gnt1_s ? sel_rd_data_s : {DATA_32_W{1'b0}};
        rsp1_error_d   = gnt1_s ? sel_err_s : 1'b0;
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q   <= 4'd0;
            rsp0_valid_q   <= 1'b0;
            rsp0_rd_data_q <= {DATA_32_W{1'b0}};
            rsp0_error_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp1_rd_data_q <= {DATA_32_W{1'b0}};
            rsp1_error_q   <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp0_rd_data_q <= rsp0_rd_data_d;
            rsp0_error_q   <= rsp0_error_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp1_rd_data_q <= rsp1_rd_data_d;
            rsp1_error_q   <= rsp1_error_d;
        end
    end

    assign req0_ready   = gnt0_s;
    assign req1_ready   = gnt1_s;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_rd_data = rsp0_rd_data_q;
    assign rsp0_error   = rsp0_error_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_rd_data = rsp1_rd_data_q;
    assign rsp1_error   = rsp1_error_q;

endmodule
